// File: rtl/svc_rst_pkg.sv
// +----------------------------------------------------------------------------+
// | svc_rst_pkg                                                                |
// | Shared state encoding and limits for the reset sequencer.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package svc_rst_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } svc_rst_seq_state_t;

    localparam int SVC_RST_MIN_SYNC = 2;

endpackage : svc_rst_pkg

`default_nettype wire

// File: rtl/svc_rst_sync.sv
// +----------------------------------------------------------------------------+
// | svc_rst_sync                                                               |
// | Release synchronizer: async clear, ones shifted in on clk.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module svc_rst_sync
    import svc_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    // Depths below the metastability minimum are silently raised to it.
    localparam int STAGES = (SYNC_STAGES < SVC_RST_MIN_SYNC) ? SVC_RST_MIN_SYNC : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_rst_n = sync_q[STAGES-1];

endmodule : svc_rst_sync

`default_nettype wire

// File: rtl/svc_rst_seq.sv
// +----------------------------------------------------------------------------+
// | svc_rst_seq                                                                |
// | Reset sequencer: async assert, synchronized + held release, soft reset    |
// | handshake. Define SVC_RST_SEQ_CNT_EN to build the saturating reset_cnt.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module svc_rst_seq
    import svc_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    output logic             rst_out_n,
    output logic             rst_done,
    output logic             rst_done_pls,
    output logic [CNT_W-1:0] reset_cnt
);

    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);

    logic sync_rst_n;

    svc_rst_seq_state_t state_q, state_d;
    logic [HCNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               rst_out_n_q, rst_out_n_d;
    logic               done_pls_q, done_pls_d;
    logic               ack_q, ack_d;

    svc_rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n)
    );

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        rst_out_n_d = rst_out_n_q;
        done_pls_d  = 1'b0;
        ack_d       = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (sync_rst_n) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    hold_cnt_d  = '0;
                    rst_out_n_d = 1'b1;
                    done_pls_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Only sampled here, so a held request re-resets once per release.
                if (soft_rst_req) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    rst_out_n_d = 1'b0;
                    ack_d       = 1'b1;
                end
            end
            default: begin
                state_d     = ST_SYNC;
                hold_cnt_d  = '0;
                rst_out_n_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            hold_cnt_q  <= '0;
            rst_out_n_q <= 1'b0;
            done_pls_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            rst_out_n_q <= rst_out_n_d;
            done_pls_q  <= done_pls_d;
            ack_q       <= ack_d;
        end
    end

    assign rst_out_n    = rst_out_n_q;
    assign rst_done     = rst_out_n_q;
    assign rst_done_pls = done_pls_q;
    assign soft_rst_ack = ack_q;

`ifdef SVC_RST_SEQ_CNT_EN
    logic [CNT_W-1:0] reset_cnt_q, reset_cnt_d;

    always_comb begin
        reset_cnt_d = reset_cnt_q;
        if (done_pls_d && (reset_cnt_q != '1)) begin
            reset_cnt_d = reset_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_cnt_q <= '0;
        end else begin
            reset_cnt_q <= reset_cnt_d;
        end
    end

    assign reset_cnt = reset_cnt_q;
`else
    assign reset_cnt = '0;
`endif

endmodule : svc_rst_seq

`default_nettype wire

// File: tb/tb_svc_rst_seq.sv
// +----------------------------------------------------------------------------+
// | tb_svc_rst_seq                                                             |
// | Self-checking bench for svc_rst_seq with a cycle-target reference model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_svc_rst_seq;

    localparam int SYNC  = 2;
    localparam int HOLD  = 4;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int NEVER = 32'h3fff_ffff;
`ifdef SVC_RST_SEQ_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          soft_rst_req = 1'b0;
    logic          soft_rst_ack;
    logic          rst_out_n;
    logic          rst_done;
    logic          rst_done_pls;
    logic [CW-1:0] reset_cnt;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int n;

    svc_rst_seq #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .rst_out_n    (rst_out_n),
        .rst_done     (rst_done),
        .rst_done_pls (rst_done_pls),
        .reset_cnt    (reset_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: outputs follow from the clock edge at which release is due.
    logic m_out  = 1'b0;
    logic m_pls  = 1'b0;
    logic m_ack  = 1'b0;
    logic m_pend = 1'b1;
    int   m_rel  = NEVER;
    int   m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out  <= 1'b0;
            m_pls  <= 1'b0;
            m_ack  <= 1'b0;
            m_pend <= 1'b1;
            m_rel  <= NEVER;
            m_cnt  <= 0;
        end else begin
            m_pls <= 1'b0;
            m_ack <= 1'b0;
            if (m_pend) begin
                m_pend <= 1'b0;
                m_rel  <= cyc + SYNC + HOLD;
            end else if (m_out && soft_rst_req) begin
                m_out <= 1'b0;
                m_ack <= 1'b1;
                m_rel <= cyc + HOLD;
            end else if (cyc == m_rel) begin
                m_out <= 1'b1;
                m_pls <= 1'b1;
                m_cnt <= (m_cnt == MAXC) ? m_cnt : m_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    int low_run = 0;

    always begin
        @(negedge clk);
        chk("m_rst_out_n", {31'd0, rst_out_n}, {31'd0, m_out});
        chk("m_rst_done", {31'd0, rst_done}, {31'd0, m_out});
        chk("m_done_pls", {31'd0, rst_done_pls}, {31'd0, m_pls});
        chk("m_ack", {31'd0, soft_rst_ack}, {31'd0, m_ack});
        chk("m_reset_cnt", {30'd0, reset_cnt}, CNT_EN ? m_cnt : 0);
        if (!rst_out_n) begin
            low_run++;
        end else begin
            if (low_run > 0) chk("min_low_pulse", {31'd0, low_run >= HOLD}, 32'd1);
            low_run = 0;
        end
    end

    // Counts negedges until rst_out_n is seen high; call right at a negedge.
    task automatic wait_release(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!rst_out_n && cnt < 40);
        if (!rst_out_n) chk("release_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        // Power-up reset
        repeat (5) @(negedge clk);
        chk("rst_out_n_in_reset", {31'd0, rst_out_n}, 32'd0);
        chk("rst_done_in_reset", {31'd0, rst_done}, 32'd0);
        chk("pls_in_reset", {31'd0, rst_done_pls}, 32'd0);
        chk("cnt_in_reset", {30'd0, reset_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("pwr_low_at_6", {31'd0, rst_out_n}, 32'd0);
        @(negedge clk);
        chk("pwr_high_at_7", {31'd0, rst_out_n}, 32'd1);
        chk("pwr_pls", {31'd0, rst_done_pls}, 32'd1);
        chk("pwr_cnt", {30'd0, reset_cnt}, CNT_EN ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("pwr_pls_once", {31'd0, rst_done_pls}, 32'd0);
        chk("pwr_done", {31'd0, rst_done}, 32'd1);

        // Async assert while running
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_low", {31'd0, rst_out_n}, 32'd0);
        chk("async_done_low", {31'd0, rst_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_release(n);
        chk("async_release_lat", n, 32'd7);

        // Single-cycle soft reset
        repeat (3) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        chk("soft_ack", {31'd0, soft_rst_ack}, 32'd1);
        chk("soft_out_low", {31'd0, rst_out_n}, 32'd0);
        wait_release(n);
        chk("soft_low_len", n, 32'd4);

        // Hard reset during hold of a soft reset
        repeat (2) @(negedge clk);
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midhold_out_low", {31'd0, rst_out_n}, 32'd0);
        rst_n = 1'b1;
        wait_release(n);
        chk("midhold_release_lat", n, 32'd7);

        // Request during reset, sync and hold, then held into run
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        soft_rst_req = 1'b1;
        @(negedge clk);
        chk("req_in_reset_no_ack", {31'd0, soft_rst_ack}, 32'd0);
        rst_n = 1'b1;
        wait_release(n);
        chk("req_held_release_lat", n, 32'd7);
        @(negedge clk);
        chk("req_held_first_run_ack", {31'd0, soft_rst_ack}, 32'd1);
        chk("req_held_rereset", {31'd0, rst_out_n}, 32'd0);
        wait_release(n);
        chk("req_held_low_len", n, 32'd4);
        repeat (12) @(negedge clk);
        soft_rst_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("sat_cnt", {30'd0, reset_cnt}, CNT_EN ? MAXC : 0);

        // Sub-cycle glitch on rst_n
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("glitch_out_low", {31'd0, rst_out_n}, 32'd0);
        wait_release(n);
        chk("glitch_release_lat", n, 32'd7);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_svc_rst_seq

`default_nettype wire
